// File: rtl/rotatix_step_sequencer.sv
// Step/direction move controller: accepts one move command at a time, emits fixed-width
// step pulses at the commanded period after a direction setup window, and tracks position.
module rotatix_step_sequencer #(
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 16,
  parameter int POS_W     = 16,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             step_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] pos
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE_HI, PULSE_LO} state_e;

  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(PULSE_CYC + 1);
  localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(SETUP_CYC - 1);
  localparam logic [DIV_W-1:0] PULSE_LAST = DIV_W'(PULSE_CYC - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] tmr_q, tmr_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             abort_pend_q, abort_pend_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             ready_q, ready_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic start_pulse;
  logic finish;
  logic finish_abort;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    period_d     = period_q;
    rem_d        = rem_q;
    abort_pend_d = abort_pend_q;
    step_d       = step_q;
    dir_d        = dir_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    ready_d      = ready_q;
    pos_d        = pos_q;
    start_pulse  = 1'b0;
    finish       = 1'b0;
    finish_abort = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end else begin
            state_d      = SETUP;
            dir_d        = cmd_dir;
            busy_d       = 1'b1;
            ready_d      = 1'b0;
            rem_d        = cmd_steps;
            period_d     = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
            tmr_d        = '0;
            abort_pend_d = 1'b0;
          end
        end
      end
      SETUP: begin
        if (abort)                    finish_abort = 1'b1;
        else if (tmr_q == SETUP_LAST) start_pulse  = 1'b1;
        else                          tmr_d        = tmr_q + DIV_W'(1);
      end
      PULSE_HI: begin
        // An abort during the high phase is remembered so the pulse is never cut short.
        abort_pend_d = abort_pend_q | abort;
        if (tmr_q == PULSE_LAST) begin
          if (abort_pend_q | abort) begin
            finish_abort = 1'b1;
          end else begin
            state_d = PULSE_LO;
            step_d  = 1'b0;
            tmr_d   = tmr_q + DIV_W'(1);
          end
        end else begin
          tmr_d = tmr_q + DIV_W'(1);
        end
      end
      PULSE_LO: begin
        if (abort) begin
          finish_abort = 1'b1;
        end else if (tmr_q == period_q - DIV_W'(1)) begin
          if (rem_q != '0) start_pulse = 1'b1;
          else             finish      = 1'b1;
        end else begin
          tmr_d = tmr_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_pulse) begin
      state_d = PULSE_HI;
      step_d  = 1'b1;
      tmr_d   = '0;
      rem_d   = rem_q - CNT_W'(1);
      pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end

    if (finish || finish_abort) begin
      state_d      = IDLE;
      step_d       = 1'b0;
      busy_d       = 1'b0;
      ready_d      = 1'b1;
      done_d       = 1'b1;
      aborted_d    = finish_abort;
      abort_pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      period_q     <= '0;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ready_q      <= 1'b1;
      pos_q        <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      period_q     <= period_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      ready_q      <= ready_d;
      pos_q        <= pos_d;
    end
  end

  assign cmd_ready = ready_q;
  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign pos       = pos_q;

endmodule

// File: doc/rotatix_step_sequencer.md
Name: rotatix_step_sequencer

Overview:
- Move-command controller for the rotatix step/direction output datapath.
- Accepts one move command at a time over a valid/ready handshake: direction, step count and step period.
- Drives a direction line with setup time and fixed-width step pulses at the commanded period.
- Tracks an absolute wrapping position, and supports a glitch-free abort.

Parameters:
- CNT_W, 16, width of cmd_steps and the remaining-step counter.
- DIV_W, 16, width of cmd_period and the period timer.
- POS_W, 16, width of the position counter (two's complement, wraps).
- SETUP_CYC, 4, cycles dir_out is stable before the first step rising edge (≥1).
- PULSE_CYC, 2, step_out high time in cycles (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_dir  in  1  1 = forward (+1 per step), 0 = reverse (−1 per step)
- cmd_steps  in  CNT_W  number of steps to issue
- cmd_period  in  DIV_W  cycles between successive step rising edges
- abort  in  1  terminate the current move
- step_out  out  1  step pulse to the driver
- dir_out  out  1  direction to the driver
- busy  out  1  move in progress
- done  out  1  one-cycle pulse when a move ends, normally or aborted
- aborted  out  1  valid with done: 1 if the move ended by abort
- pos  out  POS_W  absolute position

Behaviour:
- Reset (async, immediate):
  - state=IDLE; cmd_ready=1; step_out=0; dir_out=0; busy=0; done=0; aborted=0; pos=0.
  - All counters clear.
  - Reset mid-pulse drops step_out at once.
- All outputs are registered. The handshake completes on an edge where cmd_valid & cmd_ready; call it cycle 0.
- Latching at handshake:
  - dir, steps and period are latched.
  - eff_period = max(cmd_period, PULSE_CYC+1). Clamping is silent.
- IDLE:
  - cmd_ready=1, busy=0.
  - If cmd_steps==0: stay in IDLE. Cycle 1: done=1, aborted=0. dir_out and pos are unchanged, busy stays 0.
  - Else → SETUP. Cycle 1: dir_out=cmd_dir, busy=1, cmd_ready=0.
- SETUP:
  - Lasts SETUP_CYC cycles (cycles 1..SETUP_CYC), then → PULSE_HI.
- PULSE_HI:
  - step_out=1 for exactly PULSE_CYC cycles.
  - In the first high cycle: pos ±1 per dir (mod 2^POS_W), and remaining decrements.
  - Then → PULSE_LO.
- PULSE_LO:
  - step_out=0 until eff_period cycles have elapsed since the last rising edge.
  - If remaining≠0 → PULSE_HI.
  - Else → IDLE with done=1, aborted=0, busy=0, cmd_ready=1 in the same cycle.
- Timing:
  - First rising edge at cycle 1+SETUP_CYC.
  - Step k (0-based) rises at 1+SETUP_CYC+k·eff_period.
  - done at 1+SETUP_CYC+steps·eff_period.
- Back-to-back:
  - A new command may be handshaken in the done cycle.
  - It always re-runs SETUP, even with the same direction.
- Abort (level, sampled each edge while busy):
  - In SETUP or PULSE_LO: next cycle IDLE, done=1, aborted=1, no further step.
  - In PULSE_HI: the pulse completes its full PULSE_CYC (no runt), then IDLE with done=1, aborted=1. That step is counted in pos.
  - Ignored in IDLE. abort together with cmd_valid in IDLE: the command is accepted.
- aborted holds its value until the next done.
- cmd_* inputs are ignored while busy.
- Counter widths:
  - The remaining counter and period timer never underflow.
  - cmd_steps = 2^CNT_W−1 and cmd_period = 2^DIV_W−1 must work.

Test Plan:
- Reset: assert rst mid-move (step_out=1) → step_out, busy, pos = 0 and cmd_ready=1 immediately. Deassert → idle, no spurious done.
- Normal move, cmd_dir=1, steps=3, period=10 (SETUP_CYC=4, PULSE_CYC=2):
  - Rises at cycles 5, 15, 25, each high for 2 cycles.
  - busy cycles 1–34; done cycle 35, aborted=0; pos=3.
- Clamp: steps=2, period=1 → eff_period=3; rises at 5, 8; done at 11; pos +2.
- Zero steps: steps=0 → done cycle 1, busy never high, step_out never high, pos unchanged.
- Abort:
  - steps=5, period=10, abort pulsed at cycle 15 (2nd pulse high) → step_out low at 17, done=1 & aborted=1 at 17, pos=+2.
  - Repeat with abort at cycle 9 (PULSE_LO) → done/aborted at 10, pos=+1.
- Wrap and back-to-back:
  - pos=0; cmd_dir=0, steps=1, then a second cmd_dir=1, steps=1 offered during the done cycle.
  - pos reads 0xFFFF, then 0x0000.
  - Second first rising edge is 5 cycles after its handshake.
